// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file.
// Provides the address-width helper, the clear-engine state type and
// the default sizing constants used by the interface, top and read ports.
package reg_file_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 2;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_t;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus interface for reg_file_mp.
// Carries the write port (we/waddr/wdata), the packed read ports
// (rd_en/raddr in, rd_data/rd_valid out) and the bulk-clear control
// (clr in, busy out). Read port i occupies raddr[i*AW +: AW] and
// rd_data[i*WIDTH +: WIDTH].
//   master : the datapath side driving requests
//   slave  : the register file
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = DEF_NUM_RD
) ();

  localparam int AW = addr_w(DEPTH);

  logic                    we;
  logic [AW-1:0]           waddr;
  logic [WIDTH-1:0]        wdata;
  logic [NUM_RD-1:0]       rd_en;
  logic [NUM_RD*AW-1:0]    raddr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_valid;
  logic                    clr;
  logic                    busy;

  modport master (
    output we, waddr, wdata, rd_en, raddr, clr,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  we, waddr, wdata, rd_en, raddr, clr,
    output rd_data, rd_valid, busy
  );

endinterface

// File: rtl/reg_file_rd_port.sv
// One registered read port of the register file.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   rd_en       read request; rd_valid follows one cycle later
//   raddr       read address (full AW bits, may be out of range)
//   mem_word    stored entry at raddr (0 when out of range)
//   clearing    clear engine active this cycle
//   wr_ok       a write is being accepted this cycle
//   waddr/wdata the accepted write, for write-first bypass
//   rd_data     registered read data; holds when rd_en=0
//   rd_valid    registered read valid
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter bit ZERO_REG0 = 1'b1,
  localparam int AW       = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [AW-1:0]    raddr,
  input  logic [WIDTH-1:0] mem_word,
  input  logic             clearing,
  input  logic             wr_ok,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             in_range;

  always_comb begin
    in_range   = ({1'b0, raddr} < DEPTH_W);
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      if (!in_range) begin
        rd_data_d = '0;
      end else if (ZERO_REG0 && (raddr == '0)) begin
        rd_data_d = '0;
      end else if (clearing) begin
        rd_data_d = '0;
      end else if (wr_ok && (waddr == raddr)) begin
        rd_data_d = wdata;
      end else begin
        rd_data_d = mem_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: one write port, NUM_RD registered read ports,
// optional hard-wired zero entry 0, write-first bypass and a sequenced
// bulk-clear engine that zeroes one entry per cycle while busy is high.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears storage, outputs, engine)
//   bus    reg_file_mp_if.slave: write port, read ports, clr/busy
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_RD    = DEF_NUM_RD,
  parameter bit ZERO_REG0 = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_mp_if.slave bus
);

  localparam int          AW      = addr_w(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  clr_state_t       state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_ok;
  logic             clearing;

  always_comb begin
    clearing = (state_q == CLEAR);
    wr_ok    = bus.we && !clearing &&
               ({1'b0, bus.waddr} < DEPTH_W) &&
               !(ZERO_REG0 && (bus.waddr == '0));
  end

  // Write is applied before the clear step so a clr arriving with an
  // accepted write lets the write land and the sweep overwrite it later.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_d   = mem_q;
    if (wr_ok) begin
      mem_d[bus.waddr] = bus.wdata;
    end
    case (state_q)
      IDLE: begin
        if (bus.clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        mem_d[ptr_q] = '0;
        if (ptr_q == LAST) begin
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      mem_q   <= mem_d;
    end
  end

  logic [WIDTH-1:0] rd_data_a  [NUM_RD];
  logic             rd_valid_a [NUM_RD];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]    raddr_i;
    logic [WIDTH-1:0] mem_word;

    assign raddr_i  = bus.raddr[i*AW +: AW];
    assign mem_word = ({1'b0, raddr_i} < DEPTH_W) ? mem_q[raddr_i] : '0;

    reg_file_rd_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG0(ZERO_REG0)
    ) u_port (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_en   (bus.rd_en[i]),
      .raddr   (raddr_i),
      .mem_word(mem_word),
      .clearing(clearing),
      .wr_ok   (wr_ok),
      .waddr   (bus.waddr),
      .wdata   (bus.wdata),
      .rd_data (rd_data_a[i]),
      .rd_valid(rd_valid_a[i])
    );
  end

  always_comb begin
    bus.rd_data  = '0;
    bus.rd_valid = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      bus.rd_data[i*WIDTH +: WIDTH] = rd_data_a[i];
      bus.rd_valid[i]               = rd_valid_a[i];
    end
  end

  assign bus.busy = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp. Three instances share one stimulus stream:
//   0: DEPTH=32, ZERO_REG0=1   1: DEPTH=32, ZERO_REG0=0   2: DEPTH=20, ZERO_REG0=1
// Each is compared every cycle against an array-based reference model.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  rd_en;
  logic [9:0]  raddr;
  logic        clr;

  always #5 clk = ~clk;

  reg_file_mp_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(2)) if_a ();
  reg_file_mp_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(2)) if_z ();
  reg_file_mp_if #(.WIDTH(32), .DEPTH(20), .NUM_RD(2)) if_d ();

  assign if_a.we = we;  assign if_a.waddr = waddr; assign if_a.wdata = wdata;
  assign if_a.rd_en = rd_en; assign if_a.raddr = raddr; assign if_a.clr = clr;
  assign if_z.we = we;  assign if_z.waddr = waddr; assign if_z.wdata = wdata;
  assign if_z.rd_en = rd_en; assign if_z.raddr = raddr; assign if_z.clr = clr;
  assign if_d.we = we;  assign if_d.waddr = waddr; assign if_d.wdata = wdata;
  assign if_d.rd_en = rd_en; assign if_d.raddr = raddr; assign if_d.clr = clr;

  reg_file_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG0(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  reg_file_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG0(1'b0)) u_z (
    .clk(clk), .rst_n(rst_n), .bus(if_z.slave));
  reg_file_mp #(.WIDTH(32), .DEPTH(20), .NUM_RD(2), .ZERO_REG0(1'b1)) u_d (
    .clk(clk), .rst_n(rst_n), .bus(if_d.slave));

  logic [63:0] got_rd   [3];
  logic [1:0]  got_vld  [3];
  logic        got_busy [3];
  assign got_rd[0] = if_a.rd_data; assign got_vld[0] = if_a.rd_valid; assign got_busy[0] = if_a.busy;
  assign got_rd[1] = if_z.rd_data; assign got_vld[1] = if_z.rd_valid; assign got_busy[1] = if_z.busy;
  assign got_rd[2] = if_d.rd_data; assign got_vld[2] = if_d.rd_valid; assign got_busy[2] = if_d.busy;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: plain storage plus a count of remaining clear cycles.
  logic [31:0] m_mem  [3][32];
  logic [63:0] m_rd   [3];
  logic [1:0]  m_vld  [3];
  int          m_left [3];
  int          dep    [3] = '{32, 32, 20};
  bit          zr     [3] = '{1'b1, 1'b0, 1'b1};

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < 32; a++) m_mem[d][a] = '0;
      m_rd[d]   = '0;
      m_vld[d]  = '0;
      m_left[d] = 0;
    end
  endtask

  task automatic model_edge(input int d);
    bit          wok;
    bit          busy;
    int          a;
    int          wa;
    logic [31:0] v;
    busy = (m_left[d] > 0);
    wa   = int'(waddr);
    wok  = we && !busy && (wa < dep[d]) && !(zr[d] && wa == 0);
    for (int p = 0; p < 2; p++) begin
      a = int'(raddr[p*5 +: 5]);
      if (rd_en[p]) begin
        if (a >= dep[d] || (zr[d] && a == 0) || busy) v = '0;
        else if (wok && wa == a)                      v = wdata;
        else                                          v = m_mem[d][a];
        m_rd[d][p*32 +: 32] = v;
        m_vld[d][p] = 1'b1;
      end else begin
        m_vld[d][p] = 1'b0;
      end
    end
    if (wok) m_mem[d][wa] = wdata;
    if (busy) begin
      m_mem[d][dep[d] - m_left[d]] = '0;
      m_left[d]--;
    end else if (clr) begin
      m_left[d] = dep[d];
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) for (int d = 0; d < 3; d++) model_edge(d);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("dut%0d rd_data", d), got_rd[d], m_rd[d]);
      check($sformatf("dut%0d rd_valid", d), 64'(got_vld[d]), 64'(m_vld[d]));
      check($sformatf("dut%0d busy", d), 64'(got_busy[d]), 64'(m_left[d] > 0));
    end
  endtask

  task automatic cyc(input bit w, input int wa, input logic [31:0] wd,
                     input logic [1:0] re, input int ra0, input int ra1, input bit c);
    logic [31:0] r0, r1, wv;
    r0 = ra0; r1 = ra1; wv = wa;
    we = w; waddr = wv[4:0]; wdata = wd;
    rd_en = re; raddr = {r1[4:0], r0[4:0]}; clr = c;
    step();
  endtask

  int bcount [3];

  initial begin
    rst_n = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0; rd_en = '0; raddr = '0; clr = 1'b0;
    model_reset();
    #12;
    for (int d = 0; d < 3; d++) begin
      check("reset rd_data", got_rd[d], 64'h0);
      check("reset rd_valid", 64'(got_vld[d]), 64'h0);
      check("reset busy", 64'(got_busy[d]), 64'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // write then read
    cyc(1, 5, 32'hDEADBEEF, 2'b00, 0, 0, 0);
    cyc(0, 0, 32'h0, 2'b01, 5, 0, 0);
    check("wr_rd data", 64'(got_rd[0][31:0]), 64'hDEADBEEF);
    check("wr_rd valid", 64'(got_vld[0]), 64'h1);

    // bypass on both ports
    cyc(1, 7, 32'h12345678, 2'b11, 7, 7, 0);
    check("bypass p0", 64'(got_rd[0][31:0]), 64'h12345678);
    check("bypass p1", 64'(got_rd[0][63:32]), 64'h12345678);
    cyc(0, 0, 32'h0, 2'b01, 7, 0, 0);
    check("bypass later", 64'(got_rd[0][31:0]), 64'h12345678);

    // zero register
    cyc(1, 0, 32'hFFFFFFFF, 2'b00, 0, 0, 0);
    cyc(0, 0, 32'h0, 2'b01, 0, 0, 0);
    check("zero reg0", 64'(got_rd[0][31:0]), 64'h0);
    check("zero reg0 valid", 64'(got_vld[0][0]), 64'h1);
    check("no zero reg0", 64'(got_rd[1][31:0]), 64'hFFFFFFFF);

    // out of range on DEPTH=20
    cyc(1, 25, 32'hAAAA5555, 2'b00, 0, 0, 0);
    cyc(0, 0, 32'h0, 2'b11, 25, 5, 0);
    check("oor read", 64'(got_rd[2][31:0]), 64'h0);
    check("oor no alias", 64'(got_rd[2][63:32]), 64'hDEADBEEF);
    check("in range 25", 64'(got_rd[0][31:0]), 64'hAAAA5555);

    // bulk clear with writes and a second clr during busy
    for (int a = 0; a < 32; a++) cyc(1, a, a + 1, 2'b00, 0, 0, 0);
    cyc(0, 0, 32'h0, 2'b00, 0, 0, 1);
    for (int d = 0; d < 3; d++) bcount[d] = int'(got_busy[d]);
    for (int i = 1; i < 40; i++) begin
      cyc(i < 15, 3, 32'h0BAD0003, 2'b00, 0, 0, i == 5);
      for (int d = 0; d < 3; d++) bcount[d] += int'(got_busy[d]);
    end
    for (int d = 0; d < 3; d++) check("busy length", 64'(bcount[d]), 64'(dep[d]));
    for (int a = 0; a < 32; a += 2) begin
      cyc(0, 0, 32'h0, 2'b11, a, a + 1, 0);
      for (int d = 0; d < 3; d++) check("clear readback", got_rd[d], 64'h0);
    end

    // reset in the middle of a clear
    for (int a = 0; a < 32; a++) cyc(1, a, 32'hC0DE0000 + a, 2'b00, 0, 0, 0);
    cyc(0, 0, 32'h0, 2'b11, 4, 6, 1);
    for (int i = 1; i < 10; i++) cyc(0, 0, 32'h0, 2'b11, i, i + 1, 0);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst mid busy", 64'(got_busy[d]), 64'h0);
      check("rst mid valid", 64'(got_vld[d]), 64'h0);
      check("rst mid data", got_rd[d], 64'h0);
    end
    model_reset();
    cyc(0, 0, 32'h0, 2'b00, 0, 0, 0);
    cyc(0, 0, 32'h0, 2'b00, 0, 0, 0);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a += 2) begin
      cyc(0, 0, 32'h0, 2'b11, a, a + 1, 0);
      for (int d = 0; d < 3; d++) check("post rst readback", got_rd[d], 64'h0);
    end
    cyc(1, 9, 32'h5A5A5A5A, 2'b00, 0, 0, 0);
    cyc(0, 0, 32'h0, 2'b01, 9, 0, 0);
    check("post rst write", 64'(got_rd[0][31:0]), 64'h5A5A5A5A);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      we    = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 31));
      wdata = $urandom;
      rd_en = 2'($urandom_range(0, 3));
      raddr = 10'($urandom_range(0, 1023));
      clr   = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
